// File: rtl/valid_ready_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready handshakes on both sides.
// Storage is a plain register array read combinationally at the read pointer.
module valid_ready_fifo #(
  parameter int D_WIDTH = 6,
  parameter int A_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data,
  output logic               down_valid,
  input  logic               down_ready
);

  localparam int DEPTH = 1 << A_WIDTH;
  localparam logic [A_WIDTH:0] FULL_COUNT = {1'b1, {A_WIDTH{1'b0}}};

  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH-1:0] rd_ptr;
  logic [A_WIDTH:0]   count;
  logic [D_WIDTH-1:0] mem [DEPTH];

  logic empty;
  logic full;
  logic push;
  logic pop;

  // Handshake: a word moves on a side only in a cycle where both valid and
  // ready are high at the rising edge. A source holding valid high must keep
  // its data stable until ready is seen; ready never depends on valid.
  assign empty      = (count == '0);
  assign full       = (count == FULL_COUNT);
  assign up_ready   = !full && !rst;
  assign down_valid = !empty && !rst;
  assign push       = up_valid && up_ready;
  assign pop        = down_valid && down_ready;
  assign down_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + A_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + A_WIDTH'(1);
      case ({push, pop})
        2'b10:   count <= count + (A_WIDTH+1)'(1);
        2'b01:   count <= count - (A_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; stale words are unreachable after reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= up_data;
  end

  a_count_range: assert property (@(posedge clk) disable iff (rst) count <= FULL_COUNT);
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_valid_ready_fifo.sv
// Bench for valid_ready_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_valid_ready_fifo;

  logic       clk;
  logic       rst;
  logic [5:0] up_data;
  logic       up_valid;
  logic       up_ready;
  logic [5:0] down_data;
  logic       down_valid;
  logic       down_ready;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] exp_q[$];
  logic       model_on = 1'b0;
  logic       do_push;
  logic       do_pop;

  valid_ready_fifo #(.D_WIDTH(6), .A_WIDTH(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_data    (up_data),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .down_data  (down_data),
    .down_valid (down_valid),
    .down_ready (down_ready)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: an 8-entry queue updated from the rules of the handshake.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_on = 1'b1;
    end else if (model_on) begin
      do_push = up_valid && (exp_q.size() < 8);
      do_pop  = down_ready && (exp_q.size() != 0);
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(up_data);
    end
  end

  // Scoreboard compare, mid-cycle
  always @(negedge clk) begin
    logic exp_vld;
    logic exp_rdy;
    if (model_on) begin
      exp_vld = !rst && (exp_q.size() != 0);
      exp_rdy = !rst && (exp_q.size() < 8);
      n_tests++;
      if (down_valid !== exp_vld) begin
        n_fail++;
        $display("FAIL sb_down_valid t=%0t: got %b expected %b", $time, down_valid, exp_vld);
      end
      n_tests++;
      if (up_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL sb_up_ready t=%0t: got %b expected %b", $time, up_ready, exp_rdy);
      end
      if (exp_vld) begin
        n_tests++;
        if (down_data !== exp_q[0]) begin
          n_fail++;
          $display("FAIL sb_down_data t=%0t: got %h expected %h", $time, down_data, exp_q[0]);
        end
      end
    end
  end

  // Driver: apply one cycle of inputs just after the edge, return at mid-cycle.
  task automatic cyc(input logic r, input logic uv, input logic [5:0] ud, input logic dr);
    @(posedge clk);
    #1;
    rst        = r;
    up_valid   = uv;
    up_data    = ud;
    down_ready = dr;
    @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  initial begin
    int rcv;
    rst        = 1'b1;
    up_valid   = 1'b0;
    up_data    = '0;
    down_ready = 1'b0;

    // Reset held two cycles
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 6'd0, 1'b0);
      check("rst_up_ready", int'(up_ready), 0);
      check("rst_down_valid", int'(down_valid), 0);
    end
    cyc(1'b0, 1'b0, 6'd0, 1'b0);
    check("post_rst_up_ready", int'(up_ready), 1);
    check("post_rst_down_valid", int'(down_valid), 0);

    // Fill 1..8 with consumer stalled
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 6'(i + 1), 1'b0);

    // Overfill attempts with 6'h3F
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 6'h3F, 1'b0);
      check("full_up_ready", int'(up_ready), 0);
      check("full_head", int'(down_data), 1);
    end

    // Drain 1..8
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 6'd0, 1'b1);
      check("drain_valid", int'(down_valid), 1);
      check("drain_data", int'(down_data), i + 1);
    end
    cyc(1'b0, 1'b0, 6'd0, 1'b1);
    check("drained_empty", int'(down_valid), 0);

    // Streaming 0..63
    rcv = 0;
    for (int k = 0; k < 66; k++) begin
      cyc(1'b0, (k < 64), 6'(k), 1'b1);
      if (down_valid) rcv++;
      if (k >= 1 && k <= 64) begin
        check("stream_valid", int'(down_valid), 1);
        check("stream_data", int'(down_data), k - 1);
      end else begin
        check("stream_idle", int'(down_valid), 0);
      end
    end
    check("stream_count", rcv, 64);

    // Hold occupancy at 4 with simultaneous push/pop
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 6'(10 + i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 6'(20 + i), 1'b1);
      check("wrap_valid", int'(down_valid), 1);
      check("wrap_ready", int'(up_ready), 1);
      check("wrap_data", int'(down_data), (i < 4) ? 10 + i : 16 + i);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 6'd0, 1'b1);
      check("wrap_tail", int'(down_data), 36 + i);
    end
    cyc(1'b0, 1'b0, 6'd0, 1'b0);
    check("wrap_empty", int'(down_valid), 0);

    // Backpressure
    cyc(1'b0, 1'b1, 6'h2A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      check("bp_valid", int'(down_valid), 1);
      check("bp_data", int'(down_data), 42);
    end
    cyc(1'b0, 1'b0, 6'd0, 1'b1);
    check("bp_pop", int'(down_data), 42);

    // Reset in the middle of traffic
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 6'(48 + i), 1'b0);
    cyc(1'b1, 1'b0, 6'd0, 1'b0);
    check("mid_rst_up_ready", int'(up_ready), 0);
    check("mid_rst_down_valid", int'(down_valid), 0);
    cyc(1'b0, 1'b0, 6'd0, 1'b0);
    check("after_rst_up_ready", int'(up_ready), 1);
    check("after_rst_down_valid", int'(down_valid), 0);
    cyc(1'b0, 1'b1, 6'd5, 1'b0);
    cyc(1'b0, 1'b0, 6'd0, 1'b0);
    check("after_rst_head", int'(down_data), 5);
    cyc(1'b0, 1'b0, 6'd0, 1'b1);
    cyc(1'b0, 1'b0, 6'd0, 1'b1);
    check("after_rst_no_stale", int'(down_valid), 0);

    // Random traffic against the scoreboard
    for (int i = 0; i < 10000; i++)
      cyc(1'b0, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
